nx_ram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that turns the registered 1R1W RAM macro (active-low strobes, 2-cycle read latency, 1-cycle posted write) into a valid/ready FIFO. It sits directly upstream of the RAM: it owns the write and read pointers, issues RAM writes and reads, and absorbs the read latency in a 4-entry output skid buffer so pop runs at full rate under back-pressure. One instance per RAM-backed queue; the RAM instance remains a sibling wired to the `ram_*` ports.

---
 rtl/nx_ram_fifo_ctrl_pkg.sv | 21 ++
 rtl/nx_ram_fifo_ctrl_if.sv | 33 +++
 rtl/nx_ram_fifo_ctrl_skid4.sv | 69 ++++++
 rtl/nx_ram_fifo_ctrl.sv | 158 +++++++++++++++
 tb/tb_nx_ram_fifo_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nx_ram_fifo_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nx_fifo_pkg
// Brief    : Shared types and constants for the RAM-backed FIFO controller.
// Revision : 1.0
// ============================================================================
package nx_fifo_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fifo_state_e;

    localparam int unsigned SKID_DEPTH = 4;
    localparam int unsigned RAM_RD_LAT = 2;
    localparam int unsigned RAM_WR_VIS = 2;
    localparam int unsigned SKID_CW    = $clog2(SKID_DEPTH + 1);

endpackage
`default_nettype wire

// File: rtl/nx_ram_fifo_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nx_ram_fifo_ctrl_if
// Brief    : Queue-side push/pop handshake, flush and occupancy bundle.
// Revision : 1.0
// ============================================================================
interface nx_ram_fifo_ctrl_if #(
    parameter int WIDTH = 71,
    parameter int AW    = 11
);
    logic             push_vld;
    logic             push_rdy;
    logic [WIDTH-1:0] push_data;
    logic             pop_vld;
    logic             pop_rdy;
    logic [WIDTH-1:0] pop_data;
    logic             flush;
    logic [AW:0]      used;
    logic             empty;
    logic             full;

    modport master (
        output push_vld, push_data, pop_rdy, flush,
        input  push_rdy, pop_vld, pop_data, used, empty, full
    );

    modport slave (
        input  push_vld, push_data, pop_rdy, flush,
        output push_rdy, pop_vld, pop_data, used, empty, full
    );
endinterface
`default_nettype wire

// File: rtl/nx_ram_fifo_ctrl_skid4.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nx_fifo_skid4
// Brief    : 4-entry registered circular buffer absorbing RAM read latency.
// Revision : 1.0
// ============================================================================
module nx_fifo_skid4
    import nx_fifo_pkg::*;
#(
    parameter int WIDTH = 71
) (
    input  wire                clk,
    input  wire                rst_n,
    input  wire                i_clr,
    input  wire                i_we,
    input  wire  [WIDTH-1:0]   i_din,
    input  wire                i_pop,
    output logic [WIDTH-1:0]   o_head,
    output logic [SKID_CW-1:0] o_cnt
);
    localparam int               c_pw      = $clog2(SKID_DEPTH);
    localparam logic [c_pw-1:0]  c_idx_one = c_pw'(1);
    localparam logic [SKID_CW-1:0] c_cnt_one = SKID_CW'(1);

    logic [WIDTH-1:0]   r_mem [SKID_DEPTH];
    logic [c_pw-1:0]    r_wr_idx;
    logic [c_pw-1:0]    r_rd_idx;
    logic [SKID_CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && !i_clr) begin
            r_mem[r_wr_idx] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_cnt    <= '0;
        end else if (i_clr) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_we) begin
                r_wr_idx <= r_wr_idx + c_idx_one;
            end
            if (i_pop) begin
                r_rd_idx <= r_rd_idx + c_idx_one;
            end
            case ({i_we, i_pop})
                2'b10:   r_cnt <= r_cnt + c_cnt_one;
                2'b01:   r_cnt <= r_cnt - c_cnt_one;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_head = r_mem[r_rd_idx];
    assign o_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/nx_ram_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nx_ram_fifo_ctrl
// Brief    : Valid/ready FIFO controller in front of a registered 1R1W RAM.
// Revision : 1.0
// ============================================================================
module nx_ram_fifo_ctrl
    import nx_fifo_pkg::*;
#(
    parameter int WIDTH = 71,
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  wire                clk,
    input  wire                rst_n,
    nx_ram_fifo_ctrl_if.slave  q_if,
    output logic               o_ram_web,
    output logic [AW-1:0]      o_ram_wa,
    output logic [WIDTH-1:0]   o_ram_din,
    output logic [WIDTH-1:0]   o_ram_bwe,
    output logic               o_ram_reb,
    output logic [AW-1:0]      o_ram_ra,
    input  wire  [WIDTH-1:0]   i_ram_dout
);
    localparam int                c_crw        = SKID_CW + 1;
    localparam logic [c_crw-1:0]  c_credit_lim = c_crw'(SKID_DEPTH);
    localparam logic [AW:0]       c_full_cnt   = (AW+1)'(DEPTH);
    localparam logic [AW:0]       c_one        = (AW+1)'(1);

    fifo_state_e           r_state;
    fifo_state_e           w_state_nxt;
    logic                  r_out_en;
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [AW:0]           r_wv_ptr;
    logic [AW:0]           r_used;
    logic [RAM_WR_VIS-1:0] r_wv_pipe;
    logic [RAM_RD_LAT-1:0] r_rd_pipe;

    logic                  w_run;
    logic                  w_push_rdy;
    logic                  w_push_fire;
    logic                  w_pop_vld;
    logic                  w_pop_fire;
    logic                  w_rd_issue;
    logic                  w_pipes_idle;
    logic                  w_flush_exit;
    logic                  w_skid_we;
    logic [SKID_CW-1:0]    w_skid_cnt;
    logic [c_crw-1:0]      w_credit;
    logic [WIDTH-1:0]      w_skid_head;

    assign w_run       = (r_state == RUN);
    // Registered occupancy only: a pop at full does not open a same-cycle push slot.
    assign w_push_rdy  = r_out_en & w_run & (r_used != c_full_cnt);
    assign w_push_fire = q_if.push_vld & w_push_rdy;
    assign w_pop_vld   = w_run & (w_skid_cnt != '0);
    assign w_pop_fire  = w_pop_vld & q_if.pop_rdy;

    // Skid entries plus reads still in the RAM pipe must fit in the skid.
    always_comb begin
        w_credit = {{(c_crw-SKID_CW){1'b0}}, w_skid_cnt};
        for (int i = 0; i < RAM_RD_LAT; i++) begin
            w_credit = w_credit + {{(c_crw-1){1'b0}}, r_rd_pipe[i]};
        end
    end

    assign w_rd_issue   = w_run & (r_rd_ptr != r_wv_ptr) & (w_credit < c_credit_lim);
    assign w_pipes_idle = (r_rd_pipe == '0) && (r_wv_pipe == '0);
    assign w_skid_we    = r_rd_pipe[RAM_RD_LAT-1] & w_run;

    always_comb begin
        w_state_nxt  = r_state;
        w_flush_exit = 1'b0;
        case (r_state)
            RUN: begin
                if (q_if.flush) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (w_pipes_idle) begin
                    w_flush_exit = 1'b1;
                    w_state_nxt  = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_out_en  <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_wv_ptr  <= '0;
            r_used    <= '0;
            r_wv_pipe <= '0;
            r_rd_pipe <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_out_en  <= 1'b1;
            r_wv_pipe <= {r_wv_pipe[RAM_WR_VIS-2:0], w_push_fire};
            r_rd_pipe <= {r_rd_pipe[RAM_RD_LAT-2:0], w_rd_issue};
            if (w_push_fire) begin
                r_wr_ptr <= r_wr_ptr + c_one;
            end
            // A word becomes readable RAM_WR_VIS cycles after its write.
            if (r_wv_pipe[RAM_WR_VIS-2]) begin
                r_wv_ptr <= r_wv_ptr + c_one;
            end
            if (w_flush_exit) begin
                r_rd_ptr <= r_wr_ptr;
                r_used   <= '0;
            end else begin
                if (w_rd_issue) begin
                    r_rd_ptr <= r_rd_ptr + c_one;
                end
                case ({w_push_fire, w_pop_fire})
                    2'b10:   r_used <= r_used + c_one;
                    2'b01:   r_used <= r_used - c_one;
                    default: r_used <= r_used;
                endcase
            end
        end
    end

    nx_fifo_skid4 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_flush_exit),
        .i_we   (w_skid_we),
        .i_din  (i_ram_dout),
        .i_pop  (w_pop_fire),
        .o_head (w_skid_head),
        .o_cnt  (w_skid_cnt)
    );

    assign o_ram_web = ~w_push_fire;
    assign o_ram_wa  = w_push_fire ? r_wr_ptr[AW-1:0] : '0;
    assign o_ram_din = w_push_fire ? q_if.push_data : '0;
    assign o_ram_bwe = '1;
    assign o_ram_reb = ~w_rd_issue;
    assign o_ram_ra  = w_rd_issue ? r_rd_ptr[AW-1:0] : '0;

    assign q_if.push_rdy = w_push_rdy;
    assign q_if.pop_vld  = w_pop_vld;
    assign q_if.pop_data = w_skid_head;
    assign q_if.used     = r_used;
    assign q_if.empty    = (r_used == '0);
    assign q_if.full     = (r_used == c_full_cnt);

endmodule
`default_nettype wire

// File: tb/tb_nx_ram_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_nx_ram_fifo_ctrl
// Brief    : Randomized bench with a queue reference model and a RAM model.
// Revision : 1.0
// ============================================================================
module tb_nx_ram_fifo_ctrl;
    localparam int WIDTH = 71;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nx_ram_fifo_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) q_if ();

    logic             ram_web, ram_reb;
    logic [AW-1:0]    ram_wa, ram_ra;
    logic [WIDTH-1:0] ram_din, ram_bwe;
    logic [WIDTH-1:0] ram_dout = '0;

    nx_ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .q_if       (q_if),
        .o_ram_web  (ram_web),
        .o_ram_wa   (ram_wa),
        .o_ram_din  (ram_din),
        .o_ram_bwe  (ram_bwe),
        .o_ram_reb  (ram_reb),
        .o_ram_ra   (ram_ra),
        .i_ram_dout (ram_dout)
    );

    // RAM macro: posted write commits one cycle late, read data two cycles late.
    logic [WIDTH-1:0] ram_mem [DEPTH];
    logic             wp_vld = 1'b0;
    logic [AW-1:0]    wp_a   = '0;
    logic [WIDTH-1:0] wp_d   = '0;
    logic [WIDTH-1:0] rd_s1  = '0;
    always @(posedge clk) begin
        if (wp_vld) ram_mem[wp_a] <= wp_d;
        wp_vld <= !ram_web;
        wp_a   <= ram_wa;
        wp_d   <= ram_din;
        if (!ram_reb) rd_s1 <= ram_mem[ram_ra];
        ram_dout <= rd_s1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: the queue holds every accepted, not yet popped word.
    logic [WIDTH-1:0] mq[$];
    int unsigned      wr_cnt     = 0;
    bit               armed      = 0;
    int               flush_left = 0;
    bit               prev_stall = 0;
    logic [WIDTH-1:0] prev_data  = '0;
    bit               pfire, ofire;
    int               n_pops     = 0;

    function automatic bit model_rdy();
        return armed && (flush_left == 0) && (mq.size() < DEPTH);
    endfunction

    task automatic sample();
        bit exp_rdy;
        #1;
        exp_rdy = model_rdy();
        chk("push_rdy", 128'(q_if.push_rdy), 128'(exp_rdy));
        chk("used", 128'(q_if.used), 128'(mq.size()));
        chk("empty", 128'(q_if.empty), 128'(mq.size() == 0));
        chk("full", 128'(q_if.full), 128'(mq.size() == DEPTH));
        chk("skid_le4", 128'(u_dut.w_skid_cnt <= 4), 128'(1));
        pfire = q_if.push_vld && exp_rdy;
        chk("ram_web", 128'(ram_web), 128'(!pfire));
        if (pfire) begin
            chk("ram_wa", 128'(ram_wa), 128'(wr_cnt % DEPTH));
            chk("ram_din", 128'(ram_din), 128'(q_if.push_data));
        end
        if (flush_left > 0) chk("pop_vld_flush", 128'(q_if.pop_vld), 128'(0));
        if (prev_stall) begin
            chk("stall_vld", 128'(q_if.pop_vld), 128'(1));
            chk("stall_data", 128'(q_if.pop_data), 128'(prev_data));
        end
        if (q_if.pop_vld) begin
            chk("pop_when_empty", 128'(q_if.pop_vld), 128'(mq.size() != 0));
            if (mq.size() != 0) chk("pop_data", 128'(q_if.pop_data), 128'(mq[0]));
        end
        ofire = q_if.pop_vld && q_if.pop_rdy && (mq.size() != 0);
    endtask

    task automatic advance();
        if (pfire) begin
            mq.push_back(q_if.push_data);
            wr_cnt++;
        end
        if (ofire) begin
            void'(mq.pop_front());
            n_pops++;
        end
        prev_stall = q_if.pop_vld && !q_if.pop_rdy && !(q_if.flush && flush_left == 0);
        prev_data  = q_if.pop_data;
        if (flush_left > 0) begin
            flush_left--;
            if (flush_left == 0) mq.delete();
        end else if (q_if.flush) begin
            flush_left = 3;
        end
        armed = 1;
        @(negedge clk);
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mq.delete();
        wr_cnt = 0; armed = 0; flush_left = 0; prev_stall = 0;
        #1;
        chk("rst_push_rdy", 128'(q_if.push_rdy), 128'(0));
        chk("rst_pop_vld", 128'(q_if.pop_vld), 128'(0));
        chk("rst_used", 128'(q_if.used), 128'(0));
        chk("rst_empty", 128'(q_if.empty), 128'(1));
        chk("rst_full", 128'(q_if.full), 128'(0));
        chk("rst_ram_web", 128'(ram_web), 128'(1));
        chk("rst_ram_reb", 128'(ram_reb), 128'(1));
        chk("rst_ram_wa", 128'(ram_wa), 128'(0));
        chk("rst_ram_ra", 128'(ram_ra), 128'(0));
        chk("rst_ram_din", 128'(ram_din), 128'(0));
        chk("rst_pop_data", 128'(q_if.pop_data), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int k = 0;
        q_if.push_vld = 1'b0;
        q_if.pop_rdy  = 1'b1;
        q_if.flush    = 1'b0;
        while (mq.size() != 0 && k < 3000) begin
            tick();
            k++;
        end
        chk("drain_done", 128'(mq.size()), 128'(0));
        repeat (3) tick();
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [95:0] r96;
        r96 = {$urandom, $urandom, $urandom};
        return r96[WIDTH-1:0];
    endfunction

    initial begin
        #5_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        int pushed, cyc, bubbles, zero_cnt;
        bit seen;
        q_if.push_vld = 1'b1;
        q_if.push_data = '1;
        q_if.pop_rdy = 1'b0;
        q_if.flush = 1'b0;
        @(negedge clk);
        do_reset();
        q_if.push_vld = 1'b0;
        tick();

        // First-word latency
        q_if.push_vld = 1'b1; q_if.push_data = WIDTH'(8'h5A); q_if.pop_rdy = 1'b1;
        sample();
        chk("lat_wa0", 128'(ram_wa), 128'(0));
        chk("lat_web0", 128'(ram_web), 128'(0));
        advance();
        q_if.push_vld = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            sample();
            if (c == 2) begin
                chk("lat_reb2", 128'(ram_reb), 128'(0));
                chk("lat_ra2", 128'(ram_ra), 128'(0));
            end
            chk("lat_pop_vld", 128'(q_if.pop_vld), 128'(c == 5));
            if (c == 5) chk("lat_pop_data", 128'(q_if.pop_data), 128'(8'h5A));
            advance();
        end
        sample();
        chk("lat_used0", 128'(q_if.used), 128'(0));
        advance();

        // Continuous streaming
        pushed = 0; cyc = 0; bubbles = 0; seen = 0;
        q_if.push_vld = 1'b1; q_if.pop_rdy = 1'b1;
        while (pushed < 10000 && cyc < 12000) begin
            q_if.push_data = WIDTH'(pushed);
            sample();
            if (q_if.pop_vld) seen = 1;
            else if (seen) bubbles++;
            if (pfire) pushed++;
            advance();
            cyc++;
        end
        chk("stream_pushed", 128'(pushed), 128'(10000));
        chk("stream_bubbles", 128'(bubbles), 128'(0));
        drain();

        // Fill to full with the consumer stalled
        q_if.push_vld = 1'b1; q_if.pop_rdy = 1'b0;
        cyc = 0;
        while (mq.size() < DEPTH && cyc < 2200) begin
            q_if.push_data = rnd_word();
            tick();
            cyc++;
        end
        repeat (6) tick();
        sample();
        chk("full_flag", 128'(q_if.full), 128'(1));
        chk("full_skid_cnt", 128'(u_dut.w_skid_cnt), 128'(4));
        advance();
        q_if.pop_rdy = 1'b1; q_if.push_data = rnd_word();
        sample();
        chk("full_pop_push_rdy", 128'(q_if.push_rdy), 128'(0));
        chk("full_pop_vld", 128'(q_if.pop_vld), 128'(1));
        advance();
        q_if.pop_rdy = 1'b0;
        sample();
        chk("after_pop_push_rdy", 128'(q_if.push_rdy), 128'(1));
        advance();
        drain();

        // Random traffic with occasional flushes
        for (int i = 0; i < 4000; i++) begin
            q_if.push_vld  = ($urandom % 4) != 0;
            q_if.push_data = rnd_word();
            q_if.pop_rdy   = $urandom % 2;
            q_if.flush     = q_if.push_vld && model_rdy() && (($urandom % 300) == 0);
            tick();
        end
        drain();

        // Flush with a backlog and reads in flight
        q_if.pop_rdy = 1'b0; q_if.push_vld = 1'b1;
        for (int i = 0; i < 100; i++) begin
            q_if.push_data = rnd_word();
            tick();
        end
        q_if.push_vld = 1'b0; q_if.pop_rdy = 1'b1;
        repeat (2) tick();
        q_if.push_vld = 1'b1; q_if.push_data = rnd_word(); q_if.flush = 1'b1;
        tick();
        q_if.push_vld = 1'b0; q_if.flush = 1'b0;
        zero_cnt = 0;
        for (int c = 1; c <= 4; c++) begin
            sample();
            if (!q_if.pop_vld) zero_cnt++;
            if (c == 4) begin
                chk("flush_empty", 128'(q_if.empty), 128'(1));
                chk("flush_used", 128'(q_if.used), 128'(0));
            end
            advance();
        end
        chk("flush_pop_vld_low", 128'(zero_cnt), 128'(4));
        q_if.push_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            q_if.push_data = WIDTH'(32'hF000 + i);
            tick();
        end
        drain();

        // Reset mid-stream
        q_if.push_vld = 1'b1; q_if.pop_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            q_if.push_data = rnd_word();
            tick();
        end
        do_reset();
        n_pops = 0;
        q_if.push_vld = 1'b0;
        tick();
        q_if.push_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            q_if.push_data = WIDTH'(32'hC0DE0 + i);
            tick();
        end
        drain();
        chk("post_reset_pops", 128'(n_pops), 128'(5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
